// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared opcodes, FSM encoding and rt-usage helper
// Purpose : common definitions for the hazard/stall sequencer and its load-use detector.
// Contents: OP_* opcode constants, state_t FSM encoding, uses_rt() opcode classifier.
package pipe_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADDU = 6'b000001;
  localparam logic [5:0] OP_DIV  = 6'b000110;
  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_SC   = 6'b001011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_DIV_DONE = 2'd2
  } state_t;

  // Opcodes that read rt as a source operand; all others only read rs.
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    case (op)
      OP_ADDU, OP_DIV, OP_BEQ, OP_SC: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - decode/execute status in, pipeline control out
// Purpose : bundles the sequencer's pipeline-facing signals.
// Ports   : id_opcode/id_rs/id_rt, ex_mem_read/ex_rd/ex_branch_taken, mem_wait, stall_clr (to
//           sequencer); hazard, pc_we, ifid_we, idex_we, flush_ifid, div_start, div_wb_en,
//           stall_count (from sequencer). master = pipeline side, slave = sequencer.
interface hazard_stall_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [5:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              mem_wait;
  logic              stall_clr;

  logic              hazard;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_we;
  logic              flush_ifid;
  logic              div_start;
  logic              div_wb_en;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_wait, stall_clr,
    input  hazard, pc_we, ifid_we, idex_we, flush_ifid, div_start, div_wb_en, stall_count
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_wait, stall_clr,
    output hazard, pc_we, ifid_we, idex_we, flush_ifid, div_start, div_wb_en, stall_count
  );

endinterface

// File: rtl/hazard_stall_controller_hazard_detect.sv
// rtl/hazard_stall_controller_hazard_detect.sv - combinational load-use compare
// Purpose : flags an ID instruction that reads the register a load in EX is about to write.
// Ports   : id_opcode, id_rs, id_rt, ex_mem_read, ex_rd in; load_use out.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (uses_rt(id_opcode) && (ex_rd == id_rt)));

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / DIV / branch / mem-wait pipeline sequencer
// Purpose : drives bubble insert and PC/IF-ID/ID-EX write enables, sequences the multi-cycle
//           divider and counts stalled cycles (pc_we==0), saturating.
// Ports   : clk, rst_n (async, active-low); bus (slave) carries decode/execute status in and
//           pipeline control plus stall_count out.
module hazard_stall_controller
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 16,
  parameter int REG_AW     = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_stall_controller_if.slave  bus
);

  localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [DCW-1:0]   div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0] stall_count;
  logic             load_use;

  logic hazard_c, pc_we_c, ifid_we_c, idex_we_c, flush_c, start_c, wb_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_opcode   (bus.id_opcode),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    hazard_c    = 1'b0;
    pc_we_c     = 1'b0;
    ifid_we_c   = 1'b0;
    idex_we_c   = 1'b0;
    flush_c     = 1'b0;
    start_c     = 1'b0;
    wb_c        = 1'b0;

    case (state)
      ST_RUN: begin
        // Under mem_wait every enable stays low and no decision is taken.
        if (!bus.mem_wait) begin
          if (bus.ex_branch_taken) begin
            // Wrong-path instruction in ID (even a DIV) is squashed.
            flush_c   = 1'b1;
            hazard_c  = 1'b1;
            pc_we_c   = 1'b1;
            ifid_we_c = 1'b1;
            idex_we_c = 1'b1;
          end else if (load_use) begin
            hazard_c  = 1'b1;
            idex_we_c = 1'b1;
          end else if (bus.id_opcode == OP_DIV) begin
            start_c     = 1'b1;
            pc_we_c     = 1'b1;
            ifid_we_c   = 1'b1;
            idex_we_c   = 1'b1;
            div_cnt_nxt = DCW'(DIV_CYCLES - 1);
            state_nxt   = ST_DIV_BUSY;
          end else begin
            pc_we_c   = 1'b1;
            ifid_we_c = 1'b1;
            idex_we_c = 1'b1;
          end
        end
      end

      ST_DIV_BUSY: begin
        if (div_cnt != '0) begin
          // Divider progress does not pause for memory wait.
          div_cnt_nxt = div_cnt - 1'b1;
          if (!bus.mem_wait) begin
            hazard_c  = 1'b1;
            idex_we_c = 1'b1;
          end
        end else if (!bus.mem_wait) begin
          wb_c      = 1'b1;
          pc_we_c   = 1'b1;
          ifid_we_c = 1'b1;
          idex_we_c = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          // Result is ready but the pipeline is frozen; park it.
          state_nxt = ST_DIV_DONE;
        end
      end

      ST_DIV_DONE: begin
        if (!bus.mem_wait) begin
          wb_c      = 1'b1;
          pc_we_c   = 1'b1;
          ifid_we_c = 1'b1;
          idex_we_c = 1'b1;
          state_nxt = ST_RUN;
        end
      end

      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      div_cnt     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      if (bus.stall_clr) begin
        stall_count <= '0;
      end else if (!pc_we_c && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  // Controls are forced low while reset is asserted, regardless of state.
  assign bus.hazard      = rst_n & hazard_c;
  assign bus.pc_we       = rst_n & pc_we_c;
  assign bus.ifid_we     = rst_n & ifid_we_c;
  assign bus.idex_we     = rst_n & idex_we_c;
  assign bus.flush_ifid  = rst_n & flush_c;
  assign bus.div_start   = rst_n & start_c;
  assign bus.div_wb_en   = rst_n & wb_c;
  assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;
  import pipe_pkg::*;

  localparam int DIV_CYCLES = 8;
  localparam int CNT_W      = 4;
  localparam int REG_AW     = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  hazard_stall_controller_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W),
    .REG_AW     (REG_AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hazard, pc_we, ifid_we, idex_we, flush, start, wb;
  } exp_t;

  // Reference state: whether a divide is outstanding, how many cycles since its start,
  // and the expected stall counter value.
  bit m_in_div = 1'b0;
  int m_age    = 0;
  int m_cnt    = 0;

  logic [5:0] rt_ops [4] = '{6'b000001, 6'b000110, 6'b001001, 6'b001011};

  function automatic bit reads_rt(logic [5:0] op);
    foreach (rt_ops[i]) if (rt_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e = '0;
    bit lu;
    lu = bus.ex_mem_read && (bus.ex_rd != 0) &&
         ((bus.ex_rd == bus.id_rs) || (reads_rt(bus.id_opcode) && (bus.ex_rd == bus.id_rt)));
    if (!rst_n || bus.mem_wait) return e;
    if (m_in_div) begin
      if (m_age < DIV_CYCLES) begin
        e.hazard = 1; e.idex_we = 1;
      end else begin
        e.wb = 1; e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1;
      end
    end else if (bus.ex_branch_taken) begin
      e.flush = 1; e.hazard = 1; e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1;
    end else if (lu) begin
      e.hazard = 1; e.idex_we = 1;
    end else if (bus.id_opcode == 6'b000110) begin
      e.start = 1; e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1;
    end else begin
      e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_in_div = 1'b0;
      m_age    = 0;
      m_cnt    = 0;
    end else begin
      e = model_out();
      if (bus.stall_clr)                  m_cnt = 0;
      else if (!e.pc_we && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (m_in_div) begin
        if (e.wb) m_in_div = 1'b0;
        else      m_age = m_age + 1;
      end else if (e.start) begin
        m_in_div = 1'b1;
        m_age    = 1;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    chk("m_hazard",      int'(bus.hazard),      int'(e.hazard));
    chk("m_pc_we",       int'(bus.pc_we),       int'(e.pc_we));
    chk("m_ifid_we",     int'(bus.ifid_we),     int'(e.ifid_we));
    chk("m_idex_we",     int'(bus.idex_we),     int'(e.idex_we));
    chk("m_flush_ifid",  int'(bus.flush_ifid),  int'(e.flush));
    chk("m_div_start",   int'(bus.div_start),   int'(e.start));
    chk("m_div_wb_en",   int'(bus.div_wb_en),   int'(e.wb));
    chk("m_stall_count", int'(bus.stall_count), m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_opcode       = 6'b000000;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_wait        = 1'b0;
    bus.stall_clr       = 1'b0;
  endtask

  initial begin
    int wb_seen;
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("run_after_reset_pc_we", int'(bus.pc_we), 1);
    chk("run_after_reset_stall", int'(bus.stall_count), 0);
    tick();

    // Plain DIV: start pulse, 7 stall cycles, writeback on the 8th busy cycle.
    bus.id_opcode = 6'b000110;
    @(negedge clk);
    chk("div_start_pulse", int'(bus.div_start), 1);
    chk("div_start_hazard", int'(bus.hazard), 0);
    tick();
    idle();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("div_busy_hazard", int'(bus.hazard), 1);
      chk("div_busy_pc_we", int'(bus.pc_we), 0);
      chk("div_busy_no_wb", int'(bus.div_wb_en), 0);
      tick();
    end
    @(negedge clk);
    chk("div_wb_cycle8", int'(bus.div_wb_en), 1);
    chk("div_release_pc_we", int'(bus.pc_we), 1);
    chk("div_release_no_start", int'(bus.div_start), 0);
    tick();
    @(negedge clk);
    chk("div_wb_one_cycle", int'(bus.div_wb_en), 0);
    chk("stall_after_div", int'(bus.stall_count), 7);
    tick();

    // DIV with mem_wait asserted when the count hits zero.
    bus.id_opcode = 6'b000110;
    tick();
    idle();
    repeat (7) tick();
    bus.mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("divwait_no_wb", int'(bus.div_wb_en), 0);
      chk("divwait_pc_we", int'(bus.pc_we), 0);
      chk("divwait_hazard", int'(bus.hazard), 0);
      tick();
    end
    bus.mem_wait = 1'b0;
    @(negedge clk);
    chk("divwait_wb_after_drop", int'(bus.div_wb_en), 1);
    chk("divwait_pc_we_after_drop", int'(bus.pc_we), 1);
    tick();

    // Load-use on rs, then cleared, then r0, then rt-sensitive opcodes.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    @(negedge clk);
    chk("lu_hazard", int'(bus.hazard), 1);
    chk("lu_pc_we", int'(bus.pc_we), 0);
    chk("lu_ifid_we", int'(bus.ifid_we), 0);
    chk("lu_idex_we", int'(bus.idex_we), 1);
    tick();
    bus.ex_mem_read = 1'b0;
    @(negedge clk);
    chk("lu_cleared", int'(bus.hazard), 0);
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0;
    @(negedge clk);
    chk("lu_r0_none", int'(bus.hazard), 0);
    tick();
    bus.id_opcode = 6'b000001; bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3;
    @(negedge clk);
    chk("lu_rt_addu", int'(bus.hazard), 1);
    tick();
    bus.id_opcode = 6'b000010;
    @(negedge clk);
    chk("lu_rt_ignored", int'(bus.hazard), 0);
    tick();
    idle();

    // Taken branch squashes a DIV sitting in ID.
    bus.id_opcode = 6'b000110; bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_flush", int'(bus.flush_ifid), 1);
    chk("br_no_div_start", int'(bus.div_start), 0);
    chk("br_hazard", int'(bus.hazard), 1);
    chk("br_pc_we", int'(bus.pc_we), 1);
    tick();
    idle();
    @(negedge clk);
    chk("br_no_busy", int'(bus.hazard), 0);
    tick();

    // Reset in the middle of a divide.
    bus.id_opcode = 6'b000110;
    tick();
    idle();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_we", int'(bus.pc_we), 0);
    chk("rst_idex_we", int'(bus.idex_we), 0);
    chk("rst_hazard", int'(bus.hazard), 0);
    chk("rst_stall_count", int'(bus.stall_count), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_pc_we", int'(bus.pc_we), 1);
    chk("rst_release_hazard", int'(bus.hazard), 0);
    wb_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (bus.div_wb_en) wb_seen++;
    end
    chk("rst_no_wb", wb_seen, 0);
    tick();

    // Saturating stall counter and clear priority.
    bus.stall_clr = 1'b1;
    tick();
    bus.stall_clr = 1'b0;
    @(negedge clk);
    chk("cnt_cleared", int'(bus.stall_count), 0);
    tick();
    bus.mem_wait = 1'b1;
    repeat (20) tick();
    bus.mem_wait = 1'b0;
    @(negedge clk);
    chk("cnt_saturated", int'(bus.stall_count), 15);
    tick();
    bus.mem_wait = 1'b1; bus.stall_clr = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("cnt_clr_wins", int'(bus.stall_count), 0);
    tick();

    // Randomized traffic checked every cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      int pick;
      rst_n = ($urandom_range(0, 299) != 0);
      pick = $urandom_range(0, 6);
      case (pick)
        0: bus.id_opcode = 6'b000001;
        1: bus.id_opcode = 6'b000110;
        2: bus.id_opcode = 6'b001001;
        3: bus.id_opcode = 6'b001011;
        4: bus.id_opcode = 6'b000010;
        5: bus.id_opcode = 6'b000000;
        default: bus.id_opcode = 6'($urandom);
      endcase
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.ex_mem_read     = ($urandom_range(0, 9) < 4);
      bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
      bus.mem_wait        = ($urandom_range(0, 19) < 3);
      bus.stall_clr       = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (2) tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
